// File: rtl/mem_pkg.sv
// ============================================================
// mem_pkg: write-mode constants and state encoding shared by the TDP SRAM.
// Rev 1.0
// ============================================================
`default_nettype none

package mem_pkg;

  localparam logic WM_WRITE_FIRST = 1'b1;
  localparam logic WM_READ_FIRST  = 1'b0;

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    READY = 1'b1
  } tdp_state_e;

endpackage

`default_nettype wire

// File: rtl/dpsram_rd_pipe.sv
// ============================================================
// dpsram_rd_pipe: per-port lane mux and 1/2-stage read pipeline.
// Rev 1.0
// ============================================================
`default_nettype none

module dpsram_rd_pipe
  import mem_pkg::*;
#(
  parameter int   DATA_WIDTH   = 32,
  parameter int   BYTE_SIZE    = 8,
  parameter int   READ_LATENCY = 1,
  parameter logic WRITE_MODE   = WM_WRITE_FIRST
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_req,
  input  logic [DATA_WIDTH/BYTE_SIZE-1:0]  i_we,
  input  logic [DATA_WIDTH-1:0]            i_wdata,
  input  logic [DATA_WIDTH-1:0]            i_old,
  output logic [DATA_WIDTH-1:0]            o_rdata,
  output logic                             o_rvalid
);

  localparam int LANES = DATA_WIDTH / BYTE_SIZE;

  logic [DATA_WIDTH-1:0] w_result;
  logic [DATA_WIDTH-1:0] r_s1_data;
  logic                  r_s1_valid;

  // Own-port lanes bypass the array only in write-first mode.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign w_result[g*BYTE_SIZE +: BYTE_SIZE] =
      ((WRITE_MODE == WM_WRITE_FIRST) && i_we[g]) ? i_wdata[g*BYTE_SIZE +: BYTE_SIZE]
                                                  : i_old[g*BYTE_SIZE +: BYTE_SIZE];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_data  <= '0;
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= i_req;
      if (i_req) r_s1_data <= w_result;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] r_s2_data;
    logic                  r_s2_valid;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_s2_data  <= '0;
        r_s2_valid <= 1'b0;
      end else begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) r_s2_data <= r_s1_data;
      end
    end

    assign o_rdata  = r_s2_data;
    assign o_rvalid = r_s2_valid;
  end else begin : g_lat1
    assign o_rdata  = r_s1_data;
    assign o_rvalid = r_s1_valid;
  end

endmodule

`default_nettype wire

// File: rtl/dpsram_tdp.sv
// ============================================================
// dpsram_tdp: true dual-port SRAM with byte enables and zero-fill sweep.
// Rev 1.0
// ============================================================
`default_nettype none

module dpsram_tdp
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int DATA_DEPTH    = 1024,
  parameter int BYTE_SIZE     = 8,
  parameter int READ_LATENCY  = 1,
  parameter int WRITE_FIRST0  = 1,
  parameter int WRITE_FIRST1  = 1,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [$clog2(DATA_DEPTH)-1:0]    addr0_i,
  input  logic                             en0_i,
  input  logic [DATA_WIDTH/BYTE_SIZE-1:0]  we0_i,
  input  logic [DATA_WIDTH-1:0]            wdata0_i,
  output logic [DATA_WIDTH-1:0]            rdata0_o,
  output logic                             rvalid0_o,
  input  logic [$clog2(DATA_DEPTH)-1:0]    addr1_i,
  input  logic                             en1_i,
  input  logic [DATA_WIDTH/BYTE_SIZE-1:0]  we1_i,
  input  logic [DATA_WIDTH-1:0]            wdata1_i,
  output logic [DATA_WIDTH-1:0]            rdata1_o,
  output logic                             rvalid1_o,
  output logic                             init_busy_o
);

  localparam int ADDR_WIDTH = $clog2(DATA_DEPTH);
  localparam int LANES      = DATA_WIDTH / BYTE_SIZE;
  localparam logic [ADDR_WIDTH-1:0] C_LAST_ADDR = ADDR_WIDTH'(DATA_DEPTH - 1);
  localparam logic C_MODE0 = (WRITE_FIRST0 != 0) ? WM_WRITE_FIRST : WM_READ_FIRST;
  localparam logic C_MODE1 = (WRITE_FIRST1 != 0) ? WM_WRITE_FIRST : WM_READ_FIRST;

  tdp_state_e            r_state;
  tdp_state_e            w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [DATA_WIDTH-1:0] r_mem [DATA_DEPTH];

  logic                  w_sweep;
  logic                  w_sweep_wr;
  logic                  w_acc0;
  logic                  w_acc1;
  logic [DATA_WIDTH-1:0] w_old0;
  logic [DATA_WIDTH-1:0] w_old1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_sweep) r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sweep     = 1'b0;
    case (r_state)
      INIT: begin
        if (INIT_ON_RESET != 0) begin
          w_sweep = 1'b1;
          if (r_cnt == C_LAST_ADDR) w_state_nxt = READY;
        end else begin
          w_state_nxt = READY;
        end
      end
      READY:   w_state_nxt = READY;
      default: w_state_nxt = INIT;
    endcase
  end

  assign init_busy_o = (r_state == INIT);
  assign w_sweep_wr  = w_sweep & ~rst;
  assign w_acc0      = en0_i & (r_state == READY) & ~rst;
  assign w_acc1      = en1_i & (r_state == READY) & ~rst;

  // Both ports read the pre-edge contents, so cross-port reads see old data.
  assign w_old0 = r_mem[addr0_i];
  assign w_old1 = r_mem[addr1_i];

  // Port 1 is written last so its lanes win a same-address collision.
  always_ff @(posedge clk) begin
    if (w_sweep_wr) r_mem[r_cnt] <= '0;
    for (int l = 0; l < LANES; l++) begin
      if (w_acc0 && we0_i[l])
        r_mem[addr0_i][l*BYTE_SIZE +: BYTE_SIZE] <= wdata0_i[l*BYTE_SIZE +: BYTE_SIZE];
      if (w_acc1 && we1_i[l])
        r_mem[addr1_i][l*BYTE_SIZE +: BYTE_SIZE] <= wdata1_i[l*BYTE_SIZE +: BYTE_SIZE];
    end
  end

  dpsram_rd_pipe #(
    .DATA_WIDTH   (DATA_WIDTH),
    .BYTE_SIZE    (BYTE_SIZE),
    .READ_LATENCY (READ_LATENCY),
    .WRITE_MODE   (C_MODE0)
  ) u_rd_pipe0 (
    .clk      (clk),
    .rst      (rst),
    .i_req    (w_acc0),
    .i_we     (we0_i),
    .i_wdata  (wdata0_i),
    .i_old    (w_old0),
    .o_rdata  (rdata0_o),
    .o_rvalid (rvalid0_o)
  );

  dpsram_rd_pipe #(
    .DATA_WIDTH   (DATA_WIDTH),
    .BYTE_SIZE    (BYTE_SIZE),
    .READ_LATENCY (READ_LATENCY),
    .WRITE_MODE   (C_MODE1)
  ) u_rd_pipe1 (
    .clk      (clk),
    .rst      (rst),
    .i_req    (w_acc1),
    .i_we     (we1_i),
    .i_wdata  (wdata1_i),
    .i_old    (w_old1),
    .o_rdata  (rdata1_o),
    .o_rvalid (rvalid1_o)
  );

endmodule

`default_nettype wire

// File: tb/tb_dpsram_tdp.sv
// ============================================================
// tb_dpsram_tdp: two instances (RL1/read-first port 0, RL2/write-first) on shared stimulus.
// Rev 1.0
// ============================================================
`default_nettype none
`timescale 1ns/1ps

module tb_dpsram_tdp;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int LN    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] a0 = '0, a1 = '0;
  logic          e0 = 1'b0, e1 = 1'b0;
  logic [LN-1:0] w0 = '0, w1 = '0;
  logic [DW-1:0] d0 = '0, d1 = '0;

  logic [DW-1:0] ra0, ra1, rb0, rb1;
  logic          va0, va1, vb0, vb1, ba, bb;

  always #5 clk = ~clk;

  dpsram_tdp #(
    .DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .BYTE_SIZE(8), .READ_LATENCY(1),
    .WRITE_FIRST0(0), .WRITE_FIRST1(1), .INIT_ON_RESET(1)
  ) dut_a (
    .clk(clk), .rst(rst),
    .addr0_i(a0), .en0_i(e0), .we0_i(w0), .wdata0_i(d0), .rdata0_o(ra0), .rvalid0_o(va0),
    .addr1_i(a1), .en1_i(e1), .we1_i(w1), .wdata1_i(d1), .rdata1_o(ra1), .rvalid1_o(va1),
    .init_busy_o(ba)
  );

  dpsram_tdp #(
    .DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .BYTE_SIZE(8), .READ_LATENCY(2),
    .WRITE_FIRST0(1), .WRITE_FIRST1(1), .INIT_ON_RESET(1)
  ) dut_b (
    .clk(clk), .rst(rst),
    .addr0_i(a0), .en0_i(e0), .we0_i(w0), .wdata0_i(d0), .rdata0_o(rb0), .rvalid0_o(vb0),
    .addr1_i(a1), .en1_i(e1), .we1_i(w1), .wdata1_i(d1), .rdata1_o(rb1), .rvalid1_o(vb1),
    .init_busy_o(bb)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [LN-1:0] we);
    logic [DW-1:0] r;
    r = old;
    for (int l = 0; l < LN; l++) if (we[l]) r[l*8 +: 8] = nw[l*8 +: 8];
    return r;
  endfunction

  // Reference model: words, a cycle-stamped read history, and a sweep-age counter.
  // Streams: 0 = A port0 (RL1, read-first), 1 = A port1, 2 = B port0 (RL2, write-first), 3 = B port1.
  logic [DW-1:0] m_mem [DEPTH];
  int            since   = 0;
  bit            started = 1'b0;
  int            cyc     = 0;
  bit            hv [4][1024];
  logic [DW-1:0] hd [4][1024];
  logic [DW-1:0] e_data [4];
  bit            e_valid [4];

  always @(posedge clk) begin
    int k;
    int lat;
    int j;
    logic [DW-1:0] o0, o1;
    k = cyc;
    cyc++;
    if (rst) begin
      started = 1'b1;
      since   = 0;
      for (int s = 0; s < 4; s++) begin
        e_valid[s] = 1'b0;
        e_data[s]  = '0;
        hv[s][k]   = 1'b0;
        if (k > 0) hv[s][k-1] = 1'b0;
      end
    end else if (started) begin
      if (since < DEPTH) begin
        m_mem[since] = '0;
        since++;
        for (int s = 0; s < 4; s++) hv[s][k] = 1'b0;
      end else begin
        o0 = m_mem[a0];
        o1 = m_mem[a1];
        hv[0][k] = e0; hd[0][k] = o0;
        hv[1][k] = e1; hd[1][k] = merge(o1, d1, w1);
        hv[2][k] = e0; hd[2][k] = merge(o0, d0, w0);
        hv[3][k] = e1; hd[3][k] = merge(o1, d1, w1);
        if (e0) m_mem[a0] = merge(m_mem[a0], d0, w0);
        if (e1) m_mem[a1] = merge(m_mem[a1], d1, w1);
      end
      for (int s = 0; s < 4; s++) begin
        lat = (s < 2) ? 1 : 2;
        j   = k - lat + 1;
        if (j >= 0 && hv[s][j]) begin
          e_valid[s] = 1'b1;
          e_data[s]  = hd[s][j];
        end else begin
          e_valid[s] = 1'b0;
        end
      end
    end
    #1;
    if (started) begin
      check("busy_a",   ba,  (since < DEPTH));
      check("busy_b",   bb,  (since < DEPTH));
      check("rvalid_a0", va0, e_valid[0]);
      check("rvalid_a1", va1, e_valid[1]);
      check("rvalid_b0", vb0, e_valid[2]);
      check("rvalid_b1", vb1, e_valid[3]);
      check("rdata_a0", ra0, e_data[0]);
      check("rdata_a1", ra1, e_data[1]);
      check("rdata_b0", rb0, e_data[2]);
      check("rdata_b1", rb1, e_data[3]);
    end
  end

  task automatic drive(input logic en0, input logic [LN-1:0] we0, input logic [AW-1:0] ad0,
                       input logic [DW-1:0] dt0, input logic en1, input logic [LN-1:0] we1,
                       input logic [AW-1:0] ad1, input logic [DW-1:0] dt1);
    @(negedge clk);
    e0 = en0; w0 = we0; a0 = ad0; d0 = dt0;
    e1 = en1; w1 = we1; a1 = ad1; d1 = dt1;
    @(posedge clk);
    #2;
    e0 = 1'b0; e1 = 1'b0; w0 = '0; w1 = '0;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
  endtask

  task automatic count_busy(input string name);
    int n;
    n = 0;
    while (ba && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    check(name, n, 16);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #2;
    check("reset_rdata", ra0, 32'h0);
    check("reset_rvalid", vb0, 32'h0);
    check("reset_busy", ba, 32'h1);

    @(negedge clk);
    rst = 1'b0;
    count_busy("sweep_len");

    for (int i = 0; i < DEPTH; i++) drive(1'b1, 4'h0, AW'(i), '0, 1'b0, '0, '0, '0);
    check("sweep_rd15_valid", va0, 32'h1);
    check("sweep_rd15_data", ra0, 32'h0);
    idle();

    drive(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'hF, 4'd5, 32'hDEADBEEF);
    drive(1'b1, 4'h1, 4'd5, 32'h000000AA, 1'b0, '0, '0, '0);
    drive(1'b1, 4'h0, 4'd5, 32'h0, 1'b0, '0, '0, '0);
    check("lane_merge_a", ra0, 32'hDEADBEAA);
    idle();
    check("lane_merge_b", rb0, 32'hDEADBEAA);

    drive(1'b1, 4'hF, 4'd3, 32'h11111111, 1'b1, 4'hF, 4'd3, 32'h22222222);
    check("coll_rf_old", ra0, 32'h0);
    check("coll_p1_wf", ra1, 32'h22222222);
    idle();
    check("coll_p0_wf_own", rb0, 32'h11111111);
    drive(1'b1, 4'h0, 4'd3, 32'h0, 1'b0, '0, '0, '0);
    check("coll_p1_wins", ra0, 32'h22222222);

    drive(1'b1, 4'hF, 4'd7, 32'h77777777, 1'b0, '0, '0, '0);
    drive(1'b1, 4'h0, 4'd7, 32'h0, 1'b1, 4'hF, 4'd7, 32'h99999999);
    check("xport_old", ra0, 32'h77777777);
    drive(1'b1, 4'h0, 4'd7, 32'h0, 1'b0, '0, '0, '0);
    check("xport_new", ra0, 32'h99999999);

    drive(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'hF, 4'd2, 32'hCAFEF00D);
    drive(1'b1, 4'hF, 4'd2, 32'h12345678, 1'b0, '0, '0, '0);
    check("read_first", ra0, 32'hCAFEF00D);
    idle();
    check("write_first", rb0, 32'h12345678);

    idle();
    drive(1'b1, 4'h0, 4'd0, 32'h0, 1'b0, '0, '0, '0);
    check("rl2_n0_valid", vb0, 32'h0);
    drive(1'b1, 4'h0, 4'd1, 32'h0, 1'b0, '0, '0, '0);
    check("rl2_n1_valid", vb0, 32'h1);
    check("rl2_n1_data", rb0, 32'h0);
    drive(1'b1, 4'h0, 4'd2, 32'h0, 1'b0, '0, '0, '0);
    check("rl2_n2_valid", vb0, 32'h1);
    idle();
    check("rl2_n3_valid", vb0, 32'h1);
    check("rl2_n3_data", rb0, 32'h12345678);
    idle();
    check("rl2_n4_valid", vb0, 32'h0);
    check("rl2_n4_hold", rb0, 32'h12345678);

    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #2;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 4'hF, 4'd9, 32'hFFFFFFFF, 1'b1, 4'hF, 4'd5, 32'hFFFFFFFF);
      check("busy_no_rvalid", va0, 32'h0);
    end
    @(negedge clk);
    rst = 1'b1;
    e0 = 1'b1; w0 = 4'hF; a0 = 4'd9; d0 = 32'hFFFFFFFF;
    @(posedge clk);
    #2;
    check("midsweep_rst_busy", ba, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    count_busy("resweep_len");
    e0 = 1'b0; w0 = '0;
    drive(1'b1, 4'h0, 4'd9, 32'h0, 1'b0, '0, '0, '0);
    check("busy_write_dropped9", ra0, 32'h0);
    drive(1'b1, 4'h0, 4'd5, 32'h0, 1'b0, '0, '0, '0);
    check("resweep_cleared5", ra0, 32'h0);
    idle();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dpsram_tdp.md
# dpsram_tdp

Parametrised true dual-port SRAM model for the BOOM core's tag/data arrays and predictor tables. Both ports read and write with per-byte enables; it adds a hardware zero-initialisation sweep after reset, a selectable read latency (1 or 2), per-port write-first/read-first mode and deterministic same-address collision resolution. It replaces the single-writer simulation RAM wherever a second writer or guaranteed-clean contents are needed.

## Interface
Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of BYTE_SIZE.
- DATA_DEPTH, 1024, number of words; power of two, >= 2.
- BYTE_SIZE, 8, width of one write-enable lane.
- READ_LATENCY, 1, either 1 or 2 cycles from en to rdata.
- WRITE_FIRST0, 1, port 0 mode: 1 = write-first, 0 = read-first.
- WRITE_FIRST1, 1, port 1 mode, same encoding.
- INIT_ON_RESET, 1, 1 = zero-fill the array after reset; 0 = skip the sweep.

Ports:
- clk  in  1  single clock for both ports.
- rst  in  1  synchronous, active-high reset.
- addr0_i  in  $clog2(DATA_DEPTH)  port 0 word address.
- en0_i  in  1  port 0 access enable.
- we0_i  in  DATA_WIDTH/BYTE_SIZE  port 0 lane write enables; only acted on when en0_i is high.
- wdata0_i  in  DATA_WIDTH  port 0 write data.
- rdata0_o  out  DATA_WIDTH  port 0 read data.
- rvalid0_o  out  1  pulses high in the cycle rdata0_o carries a new result.
- addr1_i, en1_i, we1_i, wdata1_i, rdata1_o, rvalid1_o: port 1 equivalents of the port 0 signals.
- init_busy_o  out  1  high while the zero sweep runs; all port requests are ignored while it is high.

## Operation
- FSM states: INIT, READY. Reset forces INIT, clears the sweep counter to 0, and clears every rdata, rvalid and pipeline register.
- INIT with INIT_ON_RESET=1:
  - Each cycle writes 0 to array[cnt] on all lanes, then increments cnt.
  - When cnt reaches DATA_DEPTH-1, that final write occurs and the FSM moves to READY.
  - en0_i and en1_i are gated off: no array writes, no reads, no rvalid.
- INIT with INIT_ON_RESET=0: the FSM moves to READY on the first cycle after reset deasserts. Array contents are undefined.
- READY accesses, evaluated per port:
  - If en is high, each lane whose we bit is set writes wdata into that lane.
  - If en is high, a read result is produced.
  - For lanes the same port is writing: write-first returns the new data; read-first returns the old data.
  - Lanes not being written return the old data.
- Cross-port rules, same address, same cycle:
  - A read on one port while the other port writes returns the old data (read-before-write across ports).
  - Both ports writing the same lane: port 1's data is stored. Each port's own write-first read still returns its own wdata for that lane.
- Reset asserted mid-operation (during INIT or READY) immediately re-enters INIT with cnt=0 and discards in-flight reads. Array contents are not cleared until the sweep rewrites them.
- rdata holds its last value while no new read completes. rvalid is high for exactly one cycle per accepted read.

## Timing
- Reset values: rdata0_o = rdata1_o = 0, rvalid0_o = rvalid1_o = 0, init_busy_o = 1.
- INIT_ON_RESET=1: init_busy_o stays high for DATA_DEPTH cycles after the first cycle with rst low. A request is first accepted in cycle DATA_DEPTH after rst deasserts (cycle 0 being the first cycle with rst low).
- INIT_ON_RESET=0: init_busy_o falls after 1 cycle.
- READ_LATENCY=1: request in cycle N gives rdata/rvalid in cycle N+1.
- READ_LATENCY=2: request in cycle N gives rdata/rvalid in cycle N+2. The second stage is a plain register; back-to-back reads are accepted every cycle.
- Writes are visible to reads issued from the next cycle on (either port).
- No backpressure; the only stall condition is init_busy_o.

## Structure
- Shared package mem_pkg holds the write-mode constants (WM_WRITE_FIRST, WM_READ_FIRST) and the state enum tdp_state_e {INIT, READY}.
- One sub-module, dpsram_rd_pipe: per-port lane mux and latency pipeline, parametrised by READ_LATENCY and the write mode, instantiated twice.
- Array storage, the sweep counter, collision priority and the FSM stay in the top level.

## Test plan
- Reset then sweep, DATA_DEPTH=16, INIT_ON_RESET=1: init_busy_o is high for 16 cycles; port 0 reads of all 16 addresses then return 0, each with rvalid one cycle later.
- Port 1 writes 0xDEADBEEF to addr 5 with we=4'b1111, then port 0 writes we=4'b0001, data 0x000000AA: a later read of addr 5 returns 0xDEADBEAA.
- Same-cycle writes to addr 3, port 0 data 0x11111111 and port 1 data 0x22222222, all lanes: the next read of addr 3 returns 0x22222222. A port 0 read of addr 7 in the same cycle as a port 1 write to addr 7 returns the old value.
- Read-first vs write-first: with WRITE_FIRST0=0 and addr 2 holding 0xCAFEF00D, port 0 writes 0x12345678 with en=1 and gets rdata0_o=0xCAFEF00D. With WRITE_FIRST0=1 the same access gets 0x12345678.
- READ_LATENCY=2, back-to-back reads of addrs 0,1,2 in cycles N..N+2: data arrives in cycles N+2..N+4, with rvalid high exactly in those 3 cycles.
- rst pulsed during the sweep at cnt=7: busy stays high, cnt restarts at 0, and busy falls DATA_DEPTH cycles after rst deasserts. Requests issued during busy produce no rvalid and no array write.
